// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: single-cycle registered multiply, 32-cycle restoring divide.
// Stalls EX through Md_busy, pulses Md_done for one cycle, and aborts on Flush.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            Md_start,
  input  logic [2:0]      Md_op,
  input  logic [XLEN-1:0] Rs1_data,
  input  logic [XLEN-1:0] Rs2_data,
  input  logic            Flush,
  output logic            Md_busy,
  output logic            Md_done,
  output logic [XLEN-1:0] Md_result
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIXUP, S_DONE} state_t;

  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [5:0]      LAST_IT  = 6'(XLEN - 1);

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  // Accept-time decode, on the raw inputs
  logic            in_signed, in_div_zero, in_ovf;
  logic [XLEN-1:0] in_rs1_mag, in_rs2_mag;

  // Multiply datapath
  logic              mul_a_sx, mul_b_sx;
  logic [XLEN:0]     mul_a, mul_b;
  logic [2*XLEN+1:0] mul_prod;

  // Divide step and sign fixup
  logic [XLEN:0]   rem_sh, trial;
  logic            step_ok;
  logic            fix_signed;
  logic [XLEN-1:0] quo_fix, rem_fix;

  always_comb begin
    in_signed   = ~Md_op[0];
    in_div_zero = (Rs2_data == '0);
    in_ovf      = in_signed && (Rs1_data == INT_MIN) && (Rs2_data == ALL_ONES);
    in_rs1_mag  = (in_signed && Rs1_data[XLEN-1]) ? -Rs1_data : Rs1_data;
    in_rs2_mag  = (in_signed && Rs2_data[XLEN-1]) ? -Rs2_data : Rs2_data;

    mul_a_sx = ((op_q == 3'b001) || (op_q == 3'b010)) && rs1_q[XLEN-1];
    mul_b_sx = (op_q == 3'b001) && rs2_q[XLEN-1];
    mul_a    = {mul_a_sx, rs1_q};
    mul_b    = {mul_b_sx, rs2_q};
    // Sign-extend both 33-bit operands to full width so a plain product gives the signed result
    mul_prod = {{(XLEN+1){mul_a[XLEN]}}, mul_a} * {{(XLEN+1){mul_b[XLEN]}}, mul_b};

    rem_sh  = {rem_q, quo_q[XLEN-1]};
    trial   = rem_sh - {1'b0, dvs_q};
    step_ok = ~trial[XLEN];

    fix_signed = ~op_q[0];
    quo_fix    = (fix_signed && (rs1_q[XLEN-1] ^ rs2_q[XLEN-1])) ? -quo_q : quo_q;
    rem_fix    = (fix_signed && rs1_q[XLEN-1]) ? -rem_q : rem_q;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    if (Flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (Md_start) begin
            op_d  = Md_op;
            rs1_d = Rs1_data;
            rs2_d = Rs2_data;
            cnt_d = '0;
            if (!Md_op[2]) begin
              state_d = S_MUL;
            end else if (in_div_zero) begin
              result_d = Md_op[1] ? Rs1_data : ALL_ONES;
              state_d  = S_DONE;
            end else if (in_ovf) begin
              result_d = Md_op[1] ? '0 : INT_MIN;
              state_d  = S_DONE;
            end else begin
              rem_d   = '0;
              quo_d   = in_rs1_mag;
              dvs_d   = in_rs2_mag;
              state_d = S_DIV;
            end
          end
        end
        S_MUL: begin
          result_d = (op_q == 3'b000) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
          state_d  = S_DONE;
        end
        S_DIV: begin
          rem_d = step_ok ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], step_ok};
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LAST_IT) state_d = S_FIXUP;
        end
        S_FIXUP: begin
          result_d = op_q[1] ? rem_fix : quo_fix;
          state_d  = S_DONE;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign Md_busy   = ((state_q == S_IDLE) && Md_start && !Flush) ||
                     (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIXUP);
  // A flush arriving in DONE cancels the writeback as well
  assign Md_done   = (state_q == S_DONE) && !Flush;
  assign Md_result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed RV32M cases, flush/reset aborts, and random ops vs an arithmetic model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        Md_start;
  logic [2:0]  Md_op;
  logic [31:0] Rs1_data;
  logic [31:0] Rs2_data;
  logic        Flush;
  logic        Md_busy;
  logic        Md_done;
  logic [31:0] Md_result;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] last_res = 32'd0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .Md_start(Md_start), .Md_op(Md_op),
    .Rs1_data(Rs1_data), .Rs2_data(Rs2_data), .Flush(Flush),
    .Md_busy(Md_busy), .Md_done(Md_done), .Md_result(Md_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub, p;
    int              ia, ib, r;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ia  = a;
    ib  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'd0;
    r   = 0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        r = ia / ib; return r;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        r = ia % ib; return r;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 2;
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Issue one op, then follow it cycle by cycle until Md_done (bounded)
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_res;
    int          lat;
    int          got;
    logic        busy_bad;
    exp_res  = ref_md(op, a, b);
    lat      = ref_lat(op, a, b);
    got      = 0;
    busy_bad = 1'b0;
    @(negedge clk);
    Md_start = 1'b1; Md_op = op; Rs1_data = a; Rs2_data = b;
    #1 chk({tag, "_busy_start"}, {31'd0, Md_busy}, 32'd1);
    @(negedge clk);
    Md_start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      #1;
      if (Md_done) begin
        got = k;
        break;
      end
      if (!Md_busy) busy_bad = 1'b1;
      @(negedge clk);
    end
    if (got == 0) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_lat"}, got, lat);
      chk({tag, "_res"}, Md_result, exp_res);
      chk({tag, "_busy_hold"}, {31'd0, busy_bad | Md_busy}, 32'd0);
      last_res = exp_res;
      @(negedge clk);
      #1 chk({tag, "_done_pulse"}, {31'd0, Md_done}, 32'd0);
    end
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          seen;

    rst = 1'b1; Md_start = 1'b0; Md_op = 3'd0; Rs1_data = '0; Rs2_data = '0; Flush = 1'b0;
    #12;
    chk("rst_busy", {31'd0, Md_busy}, 32'd0);
    chk("rst_done", {31'd0, Md_done}, 32'd0);
    chk("rst_res", Md_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("mul", 3'd0, 32'd7, 32'd6);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("divu", 3'd5, 32'd100, 32'd7);
    run_op("remu", 3'd7, 32'd100, 32'd7);
    run_op("div_neg", 3'd4, -32'sd7, 32'd2);
    run_op("rem_neg", 3'd6, -32'sd7, 32'd2);
    run_op("div_z", 3'd4, 32'd5, 32'd0);
    run_op("rem_z", 3'd6, 32'd5, 32'd0);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    // Flush in the middle of a divide
    @(negedge clk);
    Md_start = 1'b1; Md_op = 3'd4; Rs1_data = 32'd1000; Rs2_data = 32'd3;
    @(negedge clk);
    Md_start = 1'b0;
    repeat (9) @(negedge clk);
    Flush = 1'b1;
    #1 chk("flush_done_n10", {31'd0, Md_done}, 32'd0);
    @(negedge clk);
    Flush = 1'b0;
    #1 chk("flush_idle_busy", {31'd0, Md_busy}, 32'd0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1 if (Md_done) seen = 1;
    end
    chk("flush_no_done", seen, 0);
    chk("flush_res_kept", Md_result, last_res);
    run_op("divu_after_flush", 3'd5, 32'd9, 32'd3);

    // Flush together with start in IDLE must not start anything
    @(negedge clk);
    Md_start = 1'b1; Flush = 1'b1; Md_op = 3'd0; Rs1_data = 32'd2; Rs2_data = 32'd2;
    #1 chk("flush_start_busy", {31'd0, Md_busy}, 32'd0);
    @(negedge clk);
    Md_start = 1'b0; Flush = 1'b0;
    #1 chk("flush_start_idle", {31'd0, Md_busy | Md_done}, 32'd0);

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    Md_start = 1'b1; Md_op = 3'd5; Rs1_data = 32'd12345; Rs2_data = 32'd17;
    @(negedge clk);
    Md_start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, Md_busy}, 32'd0);
    chk("arst_done", {31'd0, Md_done}, 32'd0);
    chk("arst_res", Md_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op("mul_after_rst", 3'd0, 32'd3, 32'd3);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = $urandom_range(1, 15);
        3:       b = -($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op("rand", op, a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
